irq_ctrl: RTL

//   Interrupt controller for the 6502 peripheral bus. Latches event requests from
//   up to 8 peripherals (timer shot flag, uart rx/tx, ...), masks them, picks the

---
 rtl/irq_ctrl_if.sv | 10 +
 rtl/irq_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/irq_ctrl_if.sv
// CPU register-window bus for the interrupt controller.
interface irq_ctrl_if;
  logic [1:0] addr;
  logic       we;
  logic [7:0] dbw;
  logic [7:0] dbr;

  modport master (output addr, output we, output dbw, input dbr);
  modport slave  (input addr, input we, input dbw, output dbr);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source pending latches, mask, priority encoder,
// registered IRQ line and a 4-byte CPU register window.

// One request source: input history for edge detection plus its pending latch.
module irq_src_cell (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic edge_mode,
  input  logic clr,
  output logic pend
);
  logic src_q;
  logic set;

  // Level sources set every cycle they are high; edge sources only on 0->1.
  assign set = edge_mode ? (src & ~src_q) : src;

  // History always tracks src so a mode switch sees a correct previous value;
  // a set in the same cycle as a W1C clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      src_q <= src;
      if (set)      pend <= 1'b1;
      else if (clr) pend <= 1'b0;
    end
  end
endmodule

module irq_ctrl #(
  parameter int NSRC = 4
) (
  input  logic             clk,
  input  logic             rst,
  irq_ctrl_if.slave        bus,
  input  logic [NSRC-1:0]  src,
  output logic             irq
);
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] edge_sel;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] active;
  logic            gie;
  logic            any;
  logic [2:0]      id;
  logic            unused_dbw;

  // Write-data bits beyond NSRC (and STAT bits 7:1) have no storage.
  assign unused_dbw = ^bus.dbw;

  assign clr    = (bus.we && bus.addr == 2'd0) ? bus.dbw[NSRC-1:0] : '0;
  assign active = pending & mask;
  assign any    = |active;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    irq_src_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .src       (src[i]),
      .edge_mode (edge_sel[i]),
      .clr       (clr[i]),
      .pend      (pending[i])
    );
  end

  // Lowest active index wins; scan downward so the last hit is the lowest.
  always_comb begin
    id = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (active[i]) id = 3'(i);
  end

  // Config registers and the registered IRQ line; reset beats any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask     <= '0;
      edge_sel <= '0;
      gie      <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (bus.we) begin
        case (bus.addr)
          2'd1:    mask     <= bus.dbw[NSRC-1:0];
          2'd2:    edge_sel <= bus.dbw[NSRC-1:0];
          2'd3:    gie      <= bus.dbw[0];
          default: ;
        endcase
      end
      irq <= gie & any;
    end
  end

  // Read mux: purely combinational, no side effects.
  always_comb begin
    bus.dbr = '0;
    case (bus.addr)
      2'd0: bus.dbr[NSRC-1:0] = pending;
      2'd1: bus.dbr[NSRC-1:0] = mask;
      2'd2: bus.dbr[NSRC-1:0] = edge_sel;
      2'd3: bus.dbr = {irq, 3'b000, any, id};
      default: bus.dbr = '0;
    endcase
  end
endmodule
